// File: rtl/pwm_i2c_pkg.sv
// Shared types and constants for the PWM I2C register bridge.
// Optional feature macro: PWM_BRIDGE_AUTOINC_EN (pointer auto-increment).
package pwm_i2c_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 16;

    // Byte returned when the master reads while a write is in progress
    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        WR_MSB,
        WR_LSB,
        RD_FETCH,
        RD_WAIT,
        RD_MSB,
        RD_LSB
    } state_t;

endpackage

// File: rtl/pwm_i2c_ptr.sv
// Register pointer: load from the pointer byte, optional increment with
// natural wrap at the top of the address space.
// Optional feature macro: PWM_BRIDGE_AUTOINC_EN (when undefined the pointer
// holds its loaded value, so repeated accesses target one register).
module pwm_i2c_ptr #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

`ifdef PWM_BRIDGE_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    // Pointer register; load has priority over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_o <= '0;
        end else if (load_i) begin
            ptr_o <= load_val_i;
        end else if (inc_i && AUTOINC) begin
            ptr_o <= ptr_o + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/pwm_i2c_reg_bridge.sv
// I2C byte stream to 16-bit register access bridge.
// Pointer byte first, then data words MSB first; reads prefetch one word.
// Optional feature macro: PWM_BRIDGE_AUTOINC_EN (see pwm_i2c_ptr).
module pwm_i2c_reg_bridge
    import pwm_i2c_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              rw_i,
    input  logic              stop_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    input  logic              tx_req_i,
    output logic [7:0]        tx_byte_o,
    output logic              tx_valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o
);

    state_t            state, state_nxt;
    logic [7:0]        msb_q;
    logic [DATA_W-1:0] rbuf_q;
    logic              tx_pend_q;
    logic              bus_evt;
    logic              ptr_load;
    logic              ptr_inc;

    assign bus_evt  = start_i | stop_i;
    assign ptr_load = (state == PTR) && rx_valid_i && !bus_evt;
    // Write completes on the strobe cycle; read completes when the LSB is requested
    assign ptr_inc  = wr_en_o || ((state == RD_LSB) && tx_req_i && !bus_evt);

    // addr_o is the pointer register itself, so it is valid during every strobe
    pwm_i2c_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ptr_load),
        .load_val_i (rx_byte_i[ADDR_W-1:0]),
        .inc_i      (ptr_inc),
        .ptr_o      (addr_o)
    );

    // Next-state selection; START beats STOP, both beat normal traffic
    always_comb begin
        state_nxt = state;
        if (start_i) begin
            state_nxt = rw_i ? RD_FETCH : PTR;
        end else if (stop_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                PTR:      if (rx_valid_i) state_nxt = WR_MSB;
                WR_MSB:   if (rx_valid_i) state_nxt = WR_LSB;
                WR_LSB:   if (rx_valid_i) state_nxt = WR_MSB;
                RD_FETCH: state_nxt = RD_WAIT;
                RD_WAIT:  state_nxt = RD_MSB;
                RD_MSB:   if (tx_req_i || tx_pend_q) state_nxt = RD_LSB;
                RD_LSB:   if (tx_req_i) state_nxt = RD_FETCH;
                default:  state_nxt = state;
            endcase
        end
    end

    // State register, staging/read buffers and registered outputs.
    // rd_en_o is raised on entry to RD_FETCH so it lines up with that state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            msb_q      <= '0;
            rbuf_q     <= '0;
            tx_pend_q  <= 1'b0;
            tx_byte_o  <= '0;
            tx_valid_o <= 1'b0;
            wdata_o    <= '0;
            wr_en_o    <= 1'b0;
            rd_en_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy_o     <= (state_nxt != IDLE);
            rd_en_o    <= (state_nxt == RD_FETCH);
            wr_en_o    <= 1'b0;
            tx_valid_o <= 1'b0;

            if (tx_req_i && (state == PTR || state == WR_MSB || state == WR_LSB)) begin
                tx_byte_o  <= TX_IDLE_BYTE;
                tx_valid_o <= 1'b1;
            end

            if (bus_evt) begin
                tx_pend_q <= 1'b0;
            end else begin
                case (state)
                    WR_MSB: if (rx_valid_i) msb_q <= rx_byte_i;
                    WR_LSB: if (rx_valid_i) begin
                        wr_en_o <= 1'b1;
                        wdata_o <= {msb_q, rx_byte_i};
                    end
                    RD_FETCH: if (tx_req_i) tx_pend_q <= 1'b1;
                    RD_WAIT: begin
                        rbuf_q <= rdata_i;
                        if (tx_req_i) tx_pend_q <= 1'b1;
                    end
                    RD_MSB: if (tx_req_i || tx_pend_q) begin
                        tx_byte_o  <= rbuf_q[DATA_W-1 -: 8];
                        tx_valid_o <= 1'b1;
                        tx_pend_q  <= 1'b0;
                    end
                    RD_LSB: if (tx_req_i) begin
                        tx_byte_o  <= rbuf_q[7:0];
                        tx_valid_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_i2c_reg_bridge.sv
// Directed bench for pwm_i2c_reg_bridge; expectations follow the
// PWM_BRIDGE_AUTOINC_EN setting of the build.
module tb_pwm_i2c_reg_bridge;

`ifdef PWM_BRIDGE_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        rw_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [7:0]  rx_byte_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        tx_req_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic [7:0]  addr_o;
    logic [15:0] wdata_o;
    logic        wr_en_o;
    logic        rd_en_o;
    logic [15:0] rdata_i = '0;
    logic        busy_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk_i = ~clk_i;

    pwm_i2c_reg_bridge #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .rw_i       (rw_i),
        .stop_i     (stop_i),
        .rx_byte_i  (rx_byte_i),
        .rx_valid_i (rx_valid_i),
        .tx_req_i   (tx_req_i),
        .tx_byte_o  (tx_byte_o),
        .tx_valid_o (tx_valid_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .wr_en_o    (wr_en_o),
        .rd_en_o    (rd_en_o),
        .rdata_i    (rdata_i),
        .busy_o     (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic do_start(input logic rw);
        start_i = 1'b1;
        rw_i    = rw;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    function automatic logic [63:0] all_out();
        return {28'h0, tx_byte_o, tx_valid_o, addr_o, wdata_o, wr_en_o, rd_en_o, busy_o};
    endfunction

    initial begin
        #1;
        chk("reset_outputs", all_out(), 64'h0);
        tick();
        rst_i = 1'b0;
        tick();

        // Single word write
        do_start(1'b0);
        chk("busy_after_start", busy_o, 1'b1);
        send_rx(8'h10);
        send_rx(8'hAB);
        chk("no_wr_after_msb", wr_en_o, 1'b0);
        send_rx(8'hCD);
        chk("w1_wr_en", wr_en_o, 1'b1);
        chk("w1_addr", addr_o, 8'h10);
        chk("w1_wdata", wdata_o, 16'hABCD);
        tick();
        chk("w1_wr_en_off", wr_en_o, 1'b0);
        chk("w1_ptr_after", addr_o, AUTO ? 8'h11 : 8'h10);
        do_stop();

        // Burst write across the pointer wrap
        do_start(1'b0);
        send_rx(8'hFF);
        send_rx(8'h12);
        send_rx(8'h34);
        chk("wrap_w1_en", wr_en_o, 1'b1);
        chk("wrap_w1_addr", addr_o, 8'hFF);
        chk("wrap_w1_data", wdata_o, 16'h1234);
        send_rx(8'h56);
        send_rx(8'h78);
        chk("wrap_w2_en", wr_en_o, 1'b1);
        chk("wrap_w2_addr", addr_o, AUTO ? 8'h00 : 8'hFF);
        chk("wrap_w2_data", wdata_o, 16'h5678);
        do_stop();

        // Pointer write then repeated START read, with a pending tx request
        do_start(1'b0);
        send_rx(8'h20);
        do_start(1'b1);
        chk("rd1_en", rd_en_o, 1'b1);
        chk("rd1_addr", addr_o, 8'h20);
        chk("rd1_no_wr", wr_en_o, 1'b0);
        rdata_i = 16'hBEEF;
        tick();
        chk("rd1_en_once", rd_en_o, 1'b0);
        rx_byte_i  = 8'h99;
        rx_valid_i = 1'b1;
        tx_req_i   = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        tx_req_i   = 1'b0;
        chk("pend_not_yet", tx_valid_o, 1'b0);
        tick();
        chk("tx_msb_valid", tx_valid_o, 1'b1);
        chk("tx_msb_byte", tx_byte_o, 8'hBE);
        tick();
        chk("tx_valid_pulse", tx_valid_o, 1'b0);
        chk("rx_ignored_ptr", addr_o, 8'h20);
        tx_req_i = 1'b1;
        tick();
        tx_req_i = 1'b0;
        chk("tx_lsb_valid", tx_valid_o, 1'b1);
        chk("tx_lsb_byte", tx_byte_o, 8'hEF);
        chk("rd2_en", rd_en_o, 1'b1);
        chk("rd2_addr", addr_o, AUTO ? 8'h21 : 8'h20);
        do_stop();
        tick();

        // Partial word discarded by STOP
        do_start(1'b0);
        send_rx(8'h05);
        send_rx(8'h77);
        chk("partial_busy", busy_o, 1'b1);
        do_stop();
        chk("partial_busy_drop", busy_o, 1'b0);
        chk("partial_no_wr", wr_en_o, 1'b0);
        tick();
        chk("partial_no_wr_late", wr_en_o, 1'b0);
        chk("partial_ptr", addr_o, 8'h05);

        // tx request during a write phase, then three words from ptr 0x08
        do_start(1'b0);
        tx_req_i = 1'b1;
        tick();
        tx_req_i = 1'b0;
        chk("wr_tx_valid", tx_valid_o, 1'b1);
        chk("wr_tx_byte", tx_byte_o, 8'hFF);
        send_rx(8'h08);
        for (int unsigned i = 0; i < 3; i++) begin
            send_rx(8'hC0 + 8'(i));
            send_rx(8'h01 + 8'(i));
            chk("w3_en", wr_en_o, 1'b1);
            chk("w3_addr", addr_o, AUTO ? 8'h08 + 8'(i) : 8'h08);
            chk("w3_data", wdata_o, {8'hC0 + 8'(i), 8'h01 + 8'(i)});
        end

        // START and STOP together: START wins
        start_i = 1'b1;
        stop_i  = 1'b1;
        rw_i    = 1'b0;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("start_beats_stop", busy_o, 1'b1);

        // Reset while in WR_LSB with a byte arriving
        send_rx(8'h30);
        send_rx(8'h11);
        rx_byte_i  = 8'h22;
        rx_valid_i = 1'b1;
        rst_i      = 1'b1;
        #1;
        chk("rst_async_outputs", all_out(), 64'h0);
        tick();
        rx_valid_i = 1'b0;
        rst_i      = 1'b0;
        tick();
        chk("rst_after_outputs", all_out(), 64'h0);
        send_rx(8'h55);
        chk("idle_rx_ignored", all_out(), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
